// File: rtl/gray_pkg.sv
// Shared definitions for the Gray codec/counter: operating-mode encoding
// and width-agnostic binary<->Gray helpers (callers truncate to WIDTH).
package gray_pkg;

  typedef enum logic [1:0] {
    MODE_B2G = 2'b00,
    MODE_G2B = 2'b01,
    MODE_UP  = 2'b10,
    MODE_DN  = 2'b11
  } mode_e;

  localparam int unsigned MAX_WIDTH = 32;

  // Zero-extended operands keep the MSB correct for any WIDTH <= 32.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits do not disturb the result.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b = g;
    for (int k = MAX_WIDTH-2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_out_pipe.sv
// STAGES-deep output delay line for {vld, gray, bin, wrap}. Bubbles
// (vld=0) advance like any entry but leave the payload of the receiving
// stage untouched.
module gray_out_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             i_clk_p,
  input  logic             i_rst_n,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_gray,
  input  logic [WIDTH-1:0] i_bin,
  input  logic             i_wrap,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_gray,
  output logic [WIDTH-1:0] o_bin,
  output logic             o_wrap
);

  logic [STAGES-1:0]            vld_r;
  logic [STAGES-1:0][WIDTH-1:0] gray_r;
  logic [STAGES-1:0][WIDTH-1:0] bin_r;
  logic [STAGES-1:0]            wrap_r;

  // Shift the delay line every cycle; payload only loads behind a valid entry.
  always_ff @(posedge i_clk_p or posedge i_rst_n) begin
    if (i_rst_n) begin
      vld_r  <= '0;
      gray_r <= '0;
      bin_r  <= '0;
      wrap_r <= '0;
    end else begin
      vld_r[0] <= i_vld;
      if (i_vld) begin
        gray_r[0] <= i_gray;
        bin_r[0]  <= i_bin;
        wrap_r[0] <= i_wrap;
      end else begin
        gray_r[0] <= gray_r[0];
        bin_r[0]  <= bin_r[0];
        wrap_r[0] <= wrap_r[0];
      end
      for (int s = 1; s < STAGES; s++) begin
        vld_r[s] <= vld_r[s-1];
        if (vld_r[s-1]) begin
          gray_r[s] <= gray_r[s-1];
          bin_r[s]  <= bin_r[s-1];
          wrap_r[s] <= wrap_r[s-1];
        end else begin
          gray_r[s] <= gray_r[s];
          bin_r[s]  <= bin_r[s];
          wrap_r[s] <= wrap_r[s];
        end
      end
    end
  end

  assign o_vld  = vld_r[STAGES-1];
  assign o_gray = gray_r[STAGES-1];
  assign o_bin  = bin_r[STAGES-1];
  assign o_wrap = wrap_r[STAGES-1];

endmodule

// File: rtl/gray_codec_counter.sv
// WIDTH-bit Gray engine: binary->Gray, Gray->binary, and a loadable
// up/down Gray counter with wrap flag, followed by a STAGES-deep
// registered output pipeline.
module gray_codec_counter
  import gray_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             i_clk_p,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_gray,
  output logic [WIDTH-1:0] o_bin,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  mode_e            mode_s;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_nxt_s;
  logic [WIDTH-1:0] data_gray_s;
  logic [WIDTH-1:0] data_bin_s;
  logic             res_vld_s;
  logic [WIDTH-1:0] res_gray_s;
  logic [WIDTH-1:0] res_bin_s;
  logic             res_wrap_s;

  assign mode_s      = mode_e'(i_mode);
  assign data_gray_s = WIDTH'(bin2gray(MAX_WIDTH'(i_data)));
  assign data_bin_s  = WIDTH'(gray2bin(MAX_WIDTH'(i_data)));

  // Mode decode: next count value and the stage-0 result of this operation.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    res_vld_s  = i_en;
    res_bin_s  = i_data;
    res_gray_s = data_gray_s;
    res_wrap_s = 1'b0;
    if (i_en) begin
      case (mode_s)
        MODE_B2G: begin
          res_bin_s  = i_data;
          res_gray_s = data_gray_s;
        end
        MODE_G2B: begin
          res_bin_s  = data_bin_s;
          res_gray_s = i_data;
        end
        MODE_UP, MODE_DN: begin
          if (i_load) begin
            cnt_nxt_s = i_data;
          end else if (mode_s == MODE_UP) begin
            cnt_nxt_s  = cnt_r + ONE_C;
            res_wrap_s = &cnt_r;
          end else begin
            cnt_nxt_s  = cnt_r - ONE_C;
            res_wrap_s = ~|cnt_r;
          end
          res_bin_s  = cnt_nxt_s;
          res_gray_s = WIDTH'(bin2gray(MAX_WIDTH'(cnt_nxt_s)));
        end
        default: begin
          cnt_nxt_s = cnt_r;
        end
      endcase
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register; convert modes and idle cycles leave it untouched.
  always_ff @(posedge i_clk_p or posedge i_rst_n) begin
    if (i_rst_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  gray_out_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_out_pipe (
    .i_clk_p (i_clk_p),
    .i_rst_n (i_rst_n),
    .i_vld   (res_vld_s),
    .i_gray  (res_gray_s),
    .i_bin   (res_bin_s),
    .i_wrap  (res_wrap_s),
    .o_vld   (o_vld),
    .o_gray  (o_gray),
    .o_bin   (o_bin),
    .o_wrap  (o_wrap)
  );

endmodule

// File: tb/tb_gray_codec_counter.sv
// Directed bench for gray_codec_counter: one STAGES=1 instance for the
// functional modes and one STAGES=3 instance for latency/bubble/reset.
module tb_gray_codec_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [7:0] data;

  logic       vld1, wrap1;
  logic [7:0] gray1, bin1;
  logic       vld3, wrap3;
  logic [7:0] gray3, bin3;

  int total;
  int bad;

  gray_codec_counter #(.WIDTH(8), .STAGES(1)) dut1 (
    .i_clk_p (clk), .i_rst_n (rst), .i_en (en), .i_mode (mode),
    .i_load (load), .i_data (data),
    .o_vld (vld1), .o_gray (gray1), .o_bin (bin1), .o_wrap (wrap1)
  );

  gray_codec_counter #(.WIDTH(8), .STAGES(3)) dut3 (
    .i_clk_p (clk), .i_rst_n (rst), .i_en (en), .i_mode (mode),
    .i_load (load), .i_data (data),
    .o_vld (vld3), .o_gray (gray3), .o_bin (bin3), .o_wrap (wrap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic op(input logic e, input logic [1:0] m, input logic l, input logic [7:0] d);
    en = e; mode = m; load = l; data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      op(1'b1, 2'(c), c[0], 8'(c * 37 + 5));
      total++;
      if ({vld1, gray1, bin1, wrap1, vld3, gray3, bin3, wrap3} !== 36'd0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d got vld1=%b g1=%h b1=%h w1=%b vld3=%b g3=%h b3=%h w3=%b want all 0",
                 c, vld1, gray1, bin1, wrap1, vld3, gray3, bin3, wrap3);
      end
    end
    en = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      op(1'b0, 2'b00, 1'b0, 8'hA5);
      total++;
      if (vld1 !== 1'b0 || vld3 !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cycle=%0d got vld1=%b vld3=%b want 0", c, vld1, vld3);
      end
    end
  endtask

  task automatic test_b2g_sweep();
    logic [7:0] prev;
    logic [7:0] d;
    logic [7:0] eg;
    prev = 8'h00;
    for (int i = 0; i < 256; i++) begin
      d = 8'(i);
      eg = d ^ (d >> 1);
      op(1'b1, 2'b00, 1'b1, d);
      total++;
      if (vld1 !== 1'b1 || gray1 !== eg || bin1 !== d || wrap1 !== 1'b0) begin
        bad++;
        $display("FAIL b2g i=%0d got vld=%b gray=%h bin=%h wrap=%b want 1 %h %h 0",
                 i, vld1, gray1, bin1, wrap1, eg, d);
      end
      if (i > 0) begin
        total++;
        if ($countones(gray1 ^ prev) != 1) begin
          bad++;
          $display("FAIL b2g_onebit i=%0d got gray=%h prev=%h want single-bit change", i, gray1, prev);
        end
      end
      prev = gray1;
    end
    total++;
    if (gray1 !== 8'b1000_0000) begin
      bad++;
      $display("FAIL b2g_255 got %h want 80", gray1);
    end
  endtask

  task automatic test_g2b();
    logic [7:0] b;
    logic [7:0] g;
    op(1'b1, 2'b01, 1'b1, 8'b1100_0000);
    total++;
    if (vld1 !== 1'b1 || bin1 !== 8'b1000_0000 || gray1 !== 8'b1100_0000 || wrap1 !== 1'b0) begin
      bad++;
      $display("FAIL g2b_c0 got vld=%b bin=%h gray=%h wrap=%b want 1 80 c0 0", vld1, bin1, gray1, wrap1);
    end
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      g = b ^ (b >> 1);
      op(1'b1, 2'b01, 1'b0, g);
      total++;
      if (bin1 !== b || gray1 !== g) begin
        bad++;
        $display("FAIL g2b_roundtrip i=%0d got bin=%h gray=%h want %h %h", i, bin1, gray1, b, g);
      end
    end
  endtask

  task automatic test_count_up();
    op(1'b1, 2'b10, 1'b1, 8'hFE);
    total++;
    if (vld1 !== 1'b1 || bin1 !== 8'hFE || gray1 !== 8'h81 || wrap1 !== 1'b0) begin
      bad++;
      $display("FAIL up_load got vld=%b bin=%h gray=%h wrap=%b want 1 fe 81 0", vld1, bin1, gray1, wrap1);
    end
    op(1'b1, 2'b10, 1'b0, 8'h00);
    total++;
    if (vld1 !== 1'b1 || bin1 !== 8'hFF || gray1 !== 8'h80 || wrap1 !== 1'b0) begin
      bad++;
      $display("FAIL up_ff got vld=%b bin=%h gray=%h wrap=%b want 1 ff 80 0", vld1, bin1, gray1, wrap1);
    end
    op(1'b1, 2'b10, 1'b0, 8'h00);
    total++;
    if (vld1 !== 1'b1 || bin1 !== 8'h00 || gray1 !== 8'h00 || wrap1 !== 1'b1) begin
      bad++;
      $display("FAIL up_wrap got vld=%b bin=%h gray=%h wrap=%b want 1 00 00 1", vld1, bin1, gray1, wrap1);
    end
    op(1'b0, 2'b10, 1'b0, 8'h00);
    total++;
    if (vld1 !== 1'b0) begin
      bad++;
      $display("FAIL up_bubble got vld=%b want 0", vld1);
    end
    op(1'b1, 2'b10, 1'b0, 8'h00);
    total++;
    if (bin1 !== 8'h01 || gray1 !== 8'h01 || wrap1 !== 1'b0) begin
      bad++;
      $display("FAIL up_hold got bin=%h gray=%h wrap=%b want 01 01 0", bin1, gray1, wrap1);
    end
  endtask

  task automatic test_count_down();
    rst = 1'b1;
    op(1'b0, 2'b00, 1'b0, 8'h00);
    rst = 1'b0;
    op(1'b1, 2'b11, 1'b0, 8'h33);
    total++;
    if (vld1 !== 1'b1 || bin1 !== 8'hFF || gray1 !== 8'h80 || wrap1 !== 1'b1) begin
      bad++;
      $display("FAIL dn_wrap got vld=%b bin=%h gray=%h wrap=%b want 1 ff 80 1", vld1, bin1, gray1, wrap1);
    end
    op(1'b1, 2'b00, 1'b1, 8'h55);
    total++;
    if (bin1 !== 8'h55 || gray1 !== 8'h7F || wrap1 !== 1'b0) begin
      bad++;
      $display("FAIL dn_interleave got bin=%h gray=%h wrap=%b want 55 7f 0", bin1, gray1, wrap1);
    end
    op(1'b1, 2'b11, 1'b0, 8'h00);
    total++;
    if (vld1 !== 1'b1 || bin1 !== 8'hFE || gray1 !== 8'h81 || wrap1 !== 1'b0) begin
      bad++;
      $display("FAIL dn_next got vld=%b bin=%h gray=%h wrap=%b want 1 fe 81 0", vld1, bin1, gray1, wrap1);
    end
  endtask

  task automatic test_stages();
    logic       en_tab [12];
    logic [7:0] d_tab  [12];
    logic [7:0] ed;
    en_tab = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 12; c++) d_tab[c] = 8'(8'h10 + c * 8'h0B);
    rst = 1'b1;
    op(1'b0, 2'b00, 1'b0, 8'h00);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      op(en_tab[c], 2'b00, 1'b0, d_tab[c]);
      total++;
      if (c < 2) begin
        if (vld3 !== 1'b0) begin
          bad++;
          $display("FAIL stg_fill c=%0d got vld=%b want 0", c, vld3);
        end
      end else begin
        ed = d_tab[c-2];
        if (vld3 !== en_tab[c-2] || (en_tab[c-2] && (bin3 !== ed || gray3 !== (ed ^ (ed >> 1))))) begin
          bad++;
          $display("FAIL stg_order c=%0d got vld=%b bin=%h gray=%h want vld=%b bin=%h",
                   c, vld3, bin3, gray3, en_tab[c-2], ed);
        end
      end
    end
    op(1'b1, 2'b00, 1'b0, 8'h77);
    op(1'b1, 2'b00, 1'b0, 8'h78);
    op(1'b1, 2'b00, 1'b0, 8'h79);
    rst = 1'b1;
    #1;
    total++;
    if (vld3 !== 1'b0 || bin3 !== 8'h00 || gray3 !== 8'h00) begin
      bad++;
      $display("FAIL stg_rst_async got vld=%b bin=%h gray=%h want 0 00 00", vld3, bin3, gray3);
    end
    op(1'b0, 2'b00, 1'b0, 8'h00);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      op(1'b0, 2'b00, 1'b0, 8'h00);
      total++;
      if (vld3 !== 1'b0) begin
        bad++;
        $display("FAIL stg_stale c=%0d got vld=%b want 0", c, vld3);
      end
    end
    op(1'b1, 2'b00, 1'b0, 8'hAA);
    op(1'b0, 2'b00, 1'b0, 8'h00);
    total++;
    if (vld3 !== 1'b0) begin
      bad++;
      $display("FAIL stg_early got vld=%b want 0", vld3);
    end
    op(1'b0, 2'b00, 1'b0, 8'h00);
    total++;
    if (vld3 !== 1'b1 || bin3 !== 8'hAA || gray3 !== 8'hFF) begin
      bad++;
      $display("FAIL stg_after_rst got vld=%b bin=%h gray=%h want 1 aa ff", vld3, bin3, gray3);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    en    = 1'b0;
    mode  = 2'b00;
    load  = 1'b0;
    data  = 8'h00;
    test_reset();
    test_b2g_sweep();
    test_g2b();
    test_count_up();
    test_count_down();
    test_stages();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_codec_counter.md
# gray_codec_counter

Parametrised successor to the 8-bit binary-to-Gray unit: a WIDTH-bit Gray engine with four run-time modes. The modes are binary→Gray conversion, Gray→binary conversion, and a loadable up or down Gray counter with wrap flag. A configurable output pipeline follows the engine. The block sits between the differential-clock front end (single-ended i_clk_p domain) and downstream position/pointer consumers.

## Interface
- WIDTH, 8, data/count width; legal 2..32
- STAGES, 1, output register stages (latency); legal 1..4
- i_clk_p  in  1  system clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-high
- i_en  in  1  sample strobe; one operation per cycle when high
- i_mode  in  2  00 bin→gray, 01 gray→bin, 10 count up, 11 count down
- i_load  in  1  counter modes only: load i_data into count this operation
- i_data  in  WIDTH  operand (binary in 00/10/11, Gray in 01)
- o_vld  out  1  output word valid
- o_gray  out  WIDTH  Gray-coded result
- o_bin  out  WIDTH  binary-coded result
- o_wrap  out  1  counter wrapped on this result (qualified by o_vld)

## Operation
- Internal state: count register cnt[WIDTH-1:0]; the pipeline holds STAGES entries, each {vld, gray, bin, wrap}.
- Mode 00, i_en=1: bin=i_data, gray=i_data^(i_data>>1), wrap=0. cnt untouched.
- Mode 01, i_en=1: gray=i_data, bin[WIDTH-1]=i_data[WIDTH-1], bin[k]=bin[k+1]^i_data[k], wrap=0. cnt untouched.
- Mode 10/11, i_en=1, i_load=1: cnt←i_data; result bin=i_data, gray=bin2gray(i_data), wrap=0.
- Mode 10, i_en=1, i_load=0: cnt←cnt+1 mod 2^WIDTH; result is the new value. wrap=1 iff the old cnt was all-ones.
- Mode 11, i_en=1, i_load=0: cnt←cnt−1 mod 2^WIDTH; result is the new value. wrap=1 iff the old cnt was 0.
- i_load ignored in modes 00/01.
- i_en=0: cnt holds. The pipeline still advances and inserts a bubble (vld=0); payload fields of a bubble hold their previous values.
- Mode changes are allowed on any cycle and take effect on the cycle sampled. cnt persists across convert-mode operations.
- All arithmetic is unsigned WIDTH-bit and wraps modulo 2^WIDTH; no saturation.

## Timing
- Reset (async assert, sync-to-clock deassert handled upstream): cnt=0; every stage vld=0, gray=0, bin=0, wrap=0. Hence o_vld=0, o_gray=0, o_bin=0, o_wrap=0.
- Latency: an operation sampled at edge N appears on outputs after edge N+STAGES−1 registered, i.e. o_vld high STAGES cycles after i_en sampled. STAGES=1 gives fully registered outputs one edge after sampling.
- Throughput: one result per cycle, no backpressure. Results emerge in order, one per accepted i_en.
- Back-to-back counter ops: each uses the cnt updated by the previous edge. A load followed by up yields i_data then i_data+1.
- Reset mid-operation discards all in-flight results; o_vld is 0 from the reset edge until the first new result emerges.
- o_wrap is meaningful only while o_vld=1, and is 0 on bubbles after reset.

## Structure
- Package gray_pkg: mode encoding constants (MODE_B2G=2'b00, MODE_G2B=2'b01, MODE_UP=2'b10, MODE_DN=2'b11) and pure functions bin2gray(WIDTH) and gray2bin(WIDTH).
- Top gray_codec_counter: mode decode, cnt register, stage-0 result formation.
- Sub-module gray_out_pipe: parameterised STAGES-deep delay line of {vld, gray, bin, wrap}, async reset to zero, instantiated once.

## Test plan
- Reset: hold i_rst_n=1 for 10 cycles with toggling inputs → all outputs 0, o_vld=0. Release, then i_en=0 → o_vld stays 0.
- Mode 00 sweep, WIDTH=8, i_data 0..255 on consecutive cycles → o_gray = i^(i>>1); i=255 gives 8'b10000000; consecutive o_gray differ in exactly one bit; o_bin=i_data.
- Mode 01: i_data=8'b11000000 → o_bin=8'b10000000, o_gray=8'b11000000. Round-trip all 256 Gray codes → o_bin bijective.
- Mode 10: load 8'hFE, then two up ops → results FE (wrap 0), FF (wrap 0), 00 with o_gray=0 and o_wrap=1.
- Mode 11 from reset (cnt=0), one down op → o_bin=8'hFF, o_gray=8'h80, o_wrap=1. Interleave a mode-00 op → cnt unchanged; next down gives 8'hFE.
- STAGES=3, bursts with i_en gaps, then i_rst_n pulse mid-burst → o_vld exactly 3 cycles after each accepted op, bubbles preserved in order; after reset no stale results appear.
